block_drop_control: RTL and testbench

BLOCK_DROP_CONTROL -- requirements
Module: block_drop_control

---
 rtl/block_drop_control.sv | 148 ++++++++++++++
 tb/tb_block_drop_control.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/block_drop_control.sv
`default_nettype none
// ============================================================================
// Module      : block_drop_control
// Description : Moore FSM sequencing a block-drop game datapath: edge-detected
//               start/drop keys, drop lockout timer, hit/miss scoring flow.
// Revision    : 1.0 - initial release
// ============================================================================
module block_drop_control #(
    parameter logic [3:0]  MAX_SCORE = 4'd15,
    parameter logic [23:0] LOCKOUT   = 24'd5_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       drop,
    input  logic       o,
    input  logic       c,
    input  logic [3:0] score,
    output logic       dp_clear,
    output logic       enable,
    output logic       save_x,
    output logic       ld_x,
    output logic       ld_y,
    output logic       ld_d,
    output logic       inc_row,
    output logic       inc_score,
    output logic       dec_chances,
    output logic       game_over,
    output logic       win,
    output logic [3:0] state
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_CLEAR     = 4'd1;
    localparam logic [3:0] S_LOAD      = 4'd2;
    localparam logic [3:0] S_RUN       = 4'd3;
    localparam logic [3:0] S_SETTLE    = 4'd4;
    localparam logic [3:0] S_CHECK     = 4'd5;
    localparam logic [3:0] S_HIT       = 4'd6;
    localparam logic [3:0] S_MISS      = 4'd7;
    localparam logic [3:0] S_MISS_WAIT = 4'd8;
    localparam logic [3:0] S_OVER      = 4'd9;
    localparam logic [3:0] S_WIN       = 4'd10;

    logic [3:0]  r_state;
    logic        r_start_q;
    logic        r_drop_q;
    logic        r_first_row;
    logic        r_mw_cnt;
    logic [23:0] r_lock;

    logic w_start_p;
    logic w_drop_p;
    logic w_lock_zero;
    logic w_accept;

    assign w_start_p   = start & ~r_start_q;
    assign w_drop_p    = drop & ~r_drop_q;
    assign w_lock_zero = (r_lock == 24'd0);
    assign w_accept    = (r_state == S_RUN) & w_drop_p & w_lock_zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_start_q   <= 1'b0;
            r_drop_q    <= 1'b0;
            r_first_row <= 1'b0;
            r_mw_cnt    <= 1'b0;
            r_lock      <= 24'd0;
        end else begin
            r_start_q <= start;
            r_drop_q  <= drop;

            // Lockout runs down in every state so it survives the hit/miss flow.
            if (w_accept) begin
                r_lock <= LOCKOUT;
            end else if (!w_lock_zero) begin
                r_lock <= r_lock - 24'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start_p) r_state <= S_CLEAR;
                end
                S_CLEAR: begin
                    r_first_row <= 1'b1;
                    r_state     <= S_LOAD;
                end
                S_LOAD: begin
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_accept) r_state <= S_SETTLE;
                end
                S_SETTLE: begin
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    // The first row has nothing beneath it, so it always lands.
                    if (o || r_first_row) r_state <= S_HIT;
                    else                  r_state <= S_MISS;
                end
                S_HIT: begin
                    r_first_row <= 1'b0;
                    if (score == MAX_SCORE - 4'd1) r_state <= S_WIN;
                    else                           r_state <= S_LOAD;
                end
                S_MISS: begin
                    r_mw_cnt <= 1'b0;
                    r_state  <= S_MISS_WAIT;
                end
                S_MISS_WAIT: begin
                    // Two cycles: chances register, then the c flag derived from it.
                    if (!r_mw_cnt) begin
                        r_mw_cnt <= 1'b1;
                    end else begin
                        r_mw_cnt <= 1'b0;
                        r_state  <= c ? S_LOAD : S_OVER;
                    end
                end
                S_OVER: begin
                    if (w_start_p) r_state <= S_CLEAR;
                end
                S_WIN: begin
                    if (w_start_p) r_state <= S_CLEAR;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign state       = r_state;
    assign dp_clear    = (r_state == S_CLEAR);
    assign ld_x        = (r_state == S_LOAD);
    assign ld_y        = (r_state == S_LOAD);
    assign ld_d        = (r_state == S_LOAD);
    assign enable      = (r_state == S_RUN);
    assign save_x      = (r_state == S_HIT);
    assign inc_score   = (r_state == S_HIT);
    assign inc_row     = (r_state == S_HIT);
    assign dec_chances = (r_state == S_MISS);
    assign game_over   = (r_state == S_OVER);
    assign win         = (r_state == S_WIN);

endmodule
`default_nettype wire

// File: tb/tb_block_drop_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_block_drop_control
// Description : Randomized self-checking bench for block_drop_control against
//               a time-based behavioural model of the game flow.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_block_drop_control;

    localparam int LOCK = 10;

    logic       clk = 1'b0;
    logic       reset, start, drop, o, c;
    logic [3:0] score;
    logic       dp_clear, enable, save_x, ld_x, ld_y, ld_d;
    logic       inc_row, inc_score, dec_chances, game_over, win;
    logic [3:0] state;

    block_drop_control #(
        .MAX_SCORE (4'd15),
        .LOCKOUT   (24'd10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .drop        (drop),
        .o           (o),
        .c           (c),
        .score       (score),
        .dp_clear    (dp_clear),
        .enable      (enable),
        .save_x      (save_x),
        .ld_x        (ld_x),
        .ld_y        (ld_y),
        .ld_d        (ld_d),
        .inc_row     (inc_row),
        .inc_score   (inc_score),
        .dec_chances (dec_chances),
        .game_over   (game_over),
        .win         (win),
        .state       (state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: game phase plus absolute-time bookkeeping for lockout and waits.
    int     m_phase;
    bit     m_first;
    bit     m_key_s, m_key_d;
    int     m_wait_left;
    longint m_cyc;
    longint m_drop_ok_at;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, m_cyc, got, exp);
        end
    endtask

    function automatic logic [10:0] exp_ctrl(input int ph);
        logic hit, load;
        hit  = (ph == 6);
        load = (ph == 2);
        // {dp_clear, enable, save_x, ld_x, ld_y, ld_d, inc_row, inc_score, dec_chances, game_over, win}
        return {ph == 1, ph == 3, hit, load, load, load, hit, hit, ph == 7, ph == 9, ph == 10};
    endfunction

    task automatic model_step();
        bit sp, dp;
        m_cyc++;
        if (reset) begin
            m_phase = 0; m_first = 0; m_key_s = 0; m_key_d = 0; m_wait_left = 0;
            m_drop_ok_at = 0;
            return;
        end
        sp = start && !m_key_s;
        dp = drop && !m_key_d;
        m_key_s = start;
        m_key_d = drop;
        case (m_phase)
            0, 9, 10: if (sp) m_phase = 1;
            1: begin m_first = 1; m_phase = 2; end
            2: m_phase = 3;
            3: if (dp && m_cyc >= m_drop_ok_at) begin
                   m_drop_ok_at = m_cyc + LOCK + 1;
                   m_phase = 4;
               end
            4: m_phase = 5;
            5: m_phase = (o || m_first) ? 6 : 7;
            6: begin m_first = 0; m_phase = (score == 4'd14) ? 10 : 2; end
            7: begin m_phase = 8; m_wait_left = 2; end
            8: begin
                   m_wait_left--;
                   if (m_wait_left == 0) m_phase = c ? 2 : 9;
               end
            default: m_phase = 0;
        endcase
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_eq("state", {28'd0, state}, m_phase);
        check_eq("ctrl", {21'd0, dp_clear, enable, save_x, ld_x, ld_y, ld_d,
                          inc_row, inc_score, dec_chances, game_over, win},
                 {21'd0, exp_ctrl(m_phase)});
    endtask

    initial begin
        bit held;
        m_cyc = 0; m_drop_ok_at = 0; m_phase = 0;
        reset = 1'b1; start = 1'b0; drop = 1'b0; o = 1'b0; c = 1'b1; score = 4'd0;
        repeat (3) cycle();
        reset = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            held = ((i / 250) % 2) == 1;
            if (held) begin
                // Keys held for long stretches: one pulse per press regardless of length.
                if ($urandom_range(0, 15) == 0) start = ~start;
                if ($urandom_range(0, 7) == 0)  drop  = ~drop;
            end else begin
                start = ($urandom_range(0, 5) == 0);
                drop  = ($urandom_range(0, 2) == 0);
            end
            o     = $urandom_range(0, 1);
            c     = ($urandom_range(0, 3) != 0);
            score = ($urandom_range(0, 3) == 0) ? 4'd14 : 4'($urandom_range(0, 15));
            reset = ($urandom_range(0, 299) == 0);
            cycle();
        end
        reset = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
